// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus decoder valid/ready port.
//   master : the fetch queue (drives imem request and decoder head)
//   slave  : memory model / decoder side (returns read data, redirect, ready)
interface fetch_queue_if #(
  parameter int unsigned PC_WIDTH = 9,
  parameter int unsigned DEPTH    = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                o_imem_en;
  logic [PC_WIDTH-1:0] o_imem_addr;
  logic [31:0]         i_imem_rdata;
  logic                i_redirect_valid;
  logic [PC_WIDTH-1:0] i_redirect_pc;
  logic [31:0]         o_instruction;
  logic [PC_WIDTH-1:0] o_pc;
  logic                o_valid;
  logic                i_ready;
  logic [CNT_W-1:0]    o_count;

  modport master (
    output o_imem_en, o_imem_addr, o_instruction, o_pc, o_valid, o_count,
    input  i_imem_rdata, i_redirect_valid, i_redirect_pc, i_ready
  );

  modport slave (
    input  o_imem_en, o_imem_addr, o_instruction, o_pc, o_valid, o_count,
    output i_imem_rdata, i_redirect_valid, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential PCs to a 1-cycle-latency imem,
// buffers returned words with their PCs in a DEPTH-entry FIFO, and hands the
// head to the decoder via valid/ready. A redirect flushes everything.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : fetch_queue_if.master (imem request/response, redirect, decoder port)
module fetch_queue #(
  parameter int unsigned         PC_WIDTH = 9,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic                r_inflight;
  logic [PC_WIDTH-1:0] r_inflight_pc;
  logic [31:0]         r_instr [DEPTH];
  logic [PC_WIDTH-1:0] r_pcs   [DEPTH];
  logic [AW-1:0]       r_rd_ptr;
  logic [AW-1:0]       r_wr_ptr;
  logic [CNT_W-1:0]    r_count;

  logic [CNT_W:0]      w_occ;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_valid;

  // Occupancy includes the in-flight read so a returning word always has a slot;
  // a same-cycle pop is deliberately not credited.
  assign w_occ   = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_inflight);
  assign w_issue = ~reset & ~bus.i_redirect_valid & (w_occ < (CNT_W+1)'(DEPTH));
  assign w_valid = (r_count != '0) & ~bus.i_redirect_valid;
  assign w_push  = r_inflight & ~bus.i_redirect_valid;
  assign w_pop   = w_valid & bus.i_ready;

  assign bus.o_imem_en     = w_issue;
  assign bus.o_imem_addr   = r_fetch_pc;
  assign bus.o_valid       = w_valid;
  assign bus.o_count       = r_count;
  assign bus.o_instruction = r_instr[r_rd_ptr];
  assign bus.o_pc          = r_pcs[r_rd_ptr];

  // Fetch PC, in-flight tracking, pointers and occupancy; redirect dominates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else if (bus.i_redirect_valid) begin
      r_fetch_pc <= bus.i_redirect_pc;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + PC_WIDTH'(4);
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_fetch_pc;
      end else begin
        r_inflight <= 1'b0;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_instr[i] <= '0;
        r_pcs[i]   <= '0;
      end
    end else if (w_push) begin
      r_instr[r_wr_ptr] <= bus.i_imem_rdata;
      r_pcs[r_wr_ptr]   <= r_inflight_pc;
    end
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage directly upstream of the decoder. Generates sequential PCs and issues reads to a synchronous-read instruction memory with one-cycle latency. Buffers returned words with their PCs in a DEPTH-entry FIFO and presents the head to the decoder with a valid/ready handshake. Flushes all buffered and in-flight fetches on a redirect from the branch unit.

## Interface
Parameters:
- PC_WIDTH, 9, width of PC and instruction-memory byte address
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 0, PC fetched first after reset

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- o_imem_en  output  1  read request this cycle
- o_imem_addr  output  PC_WIDTH  byte address of the request; equals fetch_pc
- i_imem_rdata  input  32  instruction word, valid the cycle after o_imem_en
- i_redirect_valid  input  1  flush and restart fetch
- i_redirect_pc  input  PC_WIDTH  new fetch PC
- o_instruction  output  32  FIFO head instruction to decoder
- o_pc  output  PC_WIDTH  FIFO head PC
- o_valid  output  1  head is valid
- i_ready  input  1  decoder accepts head this cycle
- o_count  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- State: fetch_pc, inflight flag, inflight_pc, FIFO storage (instr+pc), rd_ptr, wr_ptr, count.
- Reset: fetch_pc=RESET_PC, inflight=0, pointers=0, count=0. Outputs: o_imem_en=0, o_valid=0, o_count=0, o_imem_addr=RESET_PC, o_instruction/o_pc=don't-care (drive 0 from cleared storage).
- Issue: o_imem_en = ~i_redirect_valid & ((count + inflight) < DEPTH). On issue: fetch_pc <= fetch_pc+4 (mod 2^PC_WIDTH, wraps to 0), inflight <= 1, inflight_pc <= fetch_pc. No issue: inflight <= 0.
- Credit rule: a pop in the same cycle does not free a slot for issue until the next cycle; the FIFO can therefore never overflow.
- Response: if inflight=1 this cycle, push {i_imem_rdata, inflight_pc} at wr_ptr.
- Pop: o_valid & i_ready advances rd_ptr.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Output: o_valid = (count≠0) & ~i_redirect_valid. o_instruction/o_pc = entry at rd_ptr.
- Redirect (highest priority): count, rd_ptr, wr_ptr <= 0; inflight <= 0; the response returning this cycle is discarded; fetch_pc <= i_redirect_pc; no issue and no pop this cycle. Back-to-back redirects: the last one wins.
- No instruction content is inspected. NOPs pass through; filtering is downstream.
- Pointers wrap modulo DEPTH.

## Timing
- Reset deasserted before edge 0: edge 0 issues RESET_PC. Data is pushed at edge 1. o_valid=1 with o_pc=RESET_PC during cycle after edge 1. Issue-to-visible latency is 2 cycles.
- Steady state with i_ready=1: one instruction per cycle; consecutive o_pc differ by 4.
- Redirect at cycle N: o_valid=0 in N. First new-path issue is at N+1, and the new instruction is visible at N+3.
- i_ready low: issue continues until count+inflight=DEPTH, then o_imem_en=0. o_instruction/o_pc are held stable while o_valid & ~i_ready.
- Async reset mid-operation: all state is cleared within the same cycle, with no edge required. In-flight data is ignored after release.

## Test plan
- Reset then i_ready=1, memory returns word = address: o_pc sequence 0,4,8,12… from third cycle. o_instruction matches, and one instruction is accepted per cycle.
- i_ready=0 for 10 cycles: o_count reaches 4 and o_imem_en=0 thereafter. Head holds o_pc=0. Releasing i_ready delivers 0,4,8,12,16 with no gap or duplicate.
- Redirect to 0x040 while FIFO holds 3 entries and one is in flight: o_valid=0 that cycle and o_count=0 next. The next delivered o_pc is 0x040, and no stale PC ever appears.
- Redirect asserted two consecutive cycles (0x080 then 0x0C0): first delivered o_pc=0x0C0.
- fetch_pc near top (redirect to 0x1F8): delivered PCs 0x1F8, 0x1FC, 0x000, 0x004.
- Assert reset with FIFO full and inflight=1: o_valid, o_count, o_imem_en go to 0 immediately. After release, fetch restarts at RESET_PC.
